bpu_btb: RTL and testbench
==========================

Name: bpu_btb

Overview:
Parametrised branch prediction unit (branch target buffer plus 2-bit bimodal counters) for the next-generation 5-stage RV32I pipeline.
- Lookup side: IF-stage PC in, same-cycle predicted next PC out. Removes the fixed taken-branch flush penalty that the current HDU imposes on every branch.
- Update side: fed by the EX stage with resolved branch/jump outcomes. Produces the redirect/flush request.

Parameters:
- ENTRIES, 32, number of BTB entries; power of two, 4..256.
- XLEN, 32, address/data width.
- CNT_W, 2, prediction counter width; taken when MSB set.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset.
- i_flush  in  1  synchronous clear of all entry valid bits (fence.i).
- i_if_pc  in  XLEN  IF-stage PC for lookup.
- o_hit  out  1  valid entry with matching tag at i_if_pc.
- o_pred_taken  out  1  prediction for i_if_pc.
- o_pred_pc  out  XLEN  predicted next PC: entry target if o_pred_taken, else i_if_pc+4.
- i_upd_vld  in  1  EX stage holds a resolved branch or jump (not a bubble).
- i_upd_is_jmp  in  1  unconditional (JAL/JALR).
- i_upd_pc  in  XLEN  PC of the resolved instruction.
- i_upd_taken  in  1  actual outcome.
- i_upd_target  in  XLEN  actual target address.
- i_upd_pred_taken  in  1  prediction made for it in IF, carried down the pipeline.
- i_upd_pred_pc  in  XLEN  predicted next PC carried down the pipeline.
- o_redirect  out  1  mispredict; pipeline must flush IF/ID and ID/EX.
- o_redirect_pc  out  XLEN  correct next PC on redirect.
- o_br_cnt  out  32  resolved branch/jump count (optional feature).
- o_miss_cnt  out  32  mispredict count (optional feature).

Behaviour:
- Reset: i_rstn is asynchronous, active-low; clock is i_clk. On reset:
  - All entry valid bits = 0. Counters, tags and targets need not be reset.
  - Perf counters = 0.
  - Consequently o_hit=0, o_pred_taken=0, o_pred_pc=i_if_pc+4, o_redirect=0 after reset.
- Addressing: IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. pc[1:0] are ignored.
- Entry fields: valid, tag, target[XLEN-1:0], cnt[CNT_W-1:0], is_jmp.
- Lookup: combinational, zero latency, from the registered array.
  - o_hit = valid & tag match.
  - o_pred_taken = o_hit & (is_jmp | cnt[MSB]).
- Update: registered on the rising edge when i_upd_vld=1 and i_flush=0.
  - Hit, conditional branch: cnt saturating +1 if taken, -1 if not taken. Holds at all-ones and at zero; no wrap. Target overwritten when taken.
  - Hit, jump: target overwritten; is_jmp=1.
  - Miss and taken: allocate (direct-mapped replace). valid=1, new tag, target. cnt = weakly taken (10 for CNT_W=2, i.e. 1 followed by zeros). is_jmp = i_upd_is_jmp.
  - Miss and not taken: no allocation, array unchanged.
- Redirect: combinational from the update inputs, no latency.
  - actual_next = i_upd_taken ? i_upd_target : i_upd_pc+4.
  - o_redirect = i_upd_vld & (actual_next != i_upd_pred_pc).
  - o_redirect_pc = actual_next.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents. There is no write-through bypass.
- i_flush and i_upd_vld in the same cycle: flush wins and the update is dropped. o_redirect is still computed from the update inputs.
- All additions are modulo 2^XLEN. A PC+4 wrap to 0 is legal.

Optional Feature:
- Macro: BPU_PERF_EN.
- Defined:
  - o_br_cnt increments on every i_upd_vld.
  - o_miss_cnt increments on every o_redirect.
  - Both saturate at 32'hFFFF_FFFF, are cleared only by reset, and are unaffected by i_flush.
- Not defined: o_br_cnt and o_miss_cnt tied to 0; no counter flops synthesised.

Decomposition:
- Package bpu_pkg holds:
  - btb_entry_t packed struct (valid, tag, target, cnt, is_jmp).
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Localparam function for IDX_W.
- Sub-module bpu_sat_cnt: combinational saturating counter next-state (cnt, taken -> cnt_next), parametrised by CNT_W.

Test Plan:
- Reset then lookup i_if_pc=0x40 -> o_hit=0, o_pred_taken=0, o_pred_pc=0x44; o_br_cnt=o_miss_cnt=0.
- Update pc=0x40, taken, target=0x100, pred_pc=0x44 -> o_redirect=1, o_redirect_pc=0x100. Next cycle, lookup 0x40 -> o_hit=1, o_pred_pc=0x100 (cnt=WT).
- Three not-taken updates at 0x40 -> cnt WT->WNT->SNT->SNT (saturates). Lookup 0x40 -> o_pred_pc=0x44. Not-taken update with pred_pc=0x44 -> o_redirect=0.
- Alias pc=0xC0 (same index 16, ENTRIES=32), JAL taken, target=0x200 -> entry replaced, is_jmp=1. Lookup 0x40 -> miss; lookup 0xC0 -> taken to 0x200 regardless of cnt.
- i_flush=1 together with an update at 0x80 -> all entries invalid, 0x80 not allocated, o_redirect still driven. Assert i_rstn=0 mid-run -> outputs return to reset values immediately, asynchronously.
- BPU_PERF_EN defined, 10 updates of which 4 mispredict -> o_br_cnt=10, o_miss_cnt=4. Macro undefined -> both read 0.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
// Counter encodings, the default-configuration BTB entry layout and the
// index-width helper used to size the direct-mapped array.
package bpu_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt2_e;

   function automatic int unsigned idx_w(input int unsigned entries);
      return $clog2(entries);
   endfunction

   localparam int unsigned BTB_XLEN    = 32;
   localparam int unsigned BTB_ENTRIES = 32;
   localparam int unsigned BTB_TAG_W   = BTB_XLEN - idx_w(BTB_ENTRIES) - 2;

   // Entry layout for the default build; the top widens tag/target/cnt
   // to its own parameters with the same field order.
   typedef struct packed {
      logic                  valid;
      logic [BTB_TAG_W-1:0]  tag;
      logic [BTB_XLEN-1:0]   target;
      logic [1:0]            cnt;
      logic                  is_jmp;
   } btb_entry_t;

endpackage

// File: rtl/bpu_sat_cnt.sv
// Saturating up/down prediction counter next-state logic (combinational).
module bpu_sat_cnt #(
   parameter int unsigned CNT_W = 2
) (
   input  logic [CNT_W-1:0] i_cnt,
   input  logic             i_taken,
   output logic [CNT_W-1:0] o_cnt_next
);

   // Step toward the outcome, holding at all-ones and at zero.
   always_comb begin
      o_cnt_next = i_cnt;
      if (i_taken) begin
         if (i_cnt != '1) o_cnt_next = i_cnt + CNT_W'(1);
      end else begin
         if (i_cnt != '0) o_cnt_next = i_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/bpu_btb.sv
// Branch target buffer with bimodal counters: zero-latency lookup for the
// IF stage, update and redirect generation from the EX stage.
// Optional performance counters are built when BPU_PERF_EN is defined.
module bpu_btb
   import bpu_pkg::*;
#(
   parameter int unsigned ENTRIES = 32,
   parameter int unsigned XLEN    = 32,
   parameter int unsigned CNT_W   = 2
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_if_pc,
   output logic            o_hit,
   output logic            o_pred_taken,
   output logic [XLEN-1:0] o_pred_pc,
   input  logic            i_upd_vld,
   input  logic            i_upd_is_jmp,
   input  logic [XLEN-1:0] i_upd_pc,
   input  logic            i_upd_taken,
   input  logic [XLEN-1:0] i_upd_target,
   input  logic            i_upd_pred_taken,
   input  logic [XLEN-1:0] i_upd_pred_pc,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic [31:0]     o_br_cnt,
   output logic [31:0]     o_miss_cnt
);

   localparam int unsigned IDX_W = idx_w(ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_WT = {1'b1, {(CNT_W-1){1'b0}}};

   // Same field order as bpu_pkg::btb_entry_t, sized by this instance.
   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [XLEN-1:0]   target;
      logic [CNT_W-1:0]  cnt;
      logic              is_jmp;
   } entry_t;

   entry_t entry_q [ENTRIES];
   entry_t entry_d [ENTRIES];

   entry_t            lk_e, up_e;
   logic [IDX_W-1:0]  up_idx;
   logic              up_hit;
   logic [CNT_W-1:0]  up_cnt_next;
   logic [XLEN-1:0]   actual_next;

   // The redirect decision uses the carried predicted PC alone.
   logic unused_pred_taken;
   assign unused_pred_taken = i_upd_pred_taken;

   // Lookup from the registered array; same-cycle updates are not visible.
   always_comb begin
      lk_e         = entry_q[i_if_pc[IDX_W+1:2]];
      o_hit        = lk_e.valid && (lk_e.tag == i_if_pc[XLEN-1:IDX_W+2]);
      o_pred_taken = o_hit && (lk_e.is_jmp || lk_e.cnt[CNT_W-1]);
      o_pred_pc    = o_pred_taken ? lk_e.target : i_if_pc + XLEN'(4);
   end

   // Mispredict detection from the resolved outcome.
   always_comb begin
      actual_next   = i_upd_taken ? i_upd_target : i_upd_pc + XLEN'(4);
      o_redirect    = i_upd_vld && (actual_next != i_upd_pred_pc);
      o_redirect_pc = actual_next;
   end

   bpu_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
      .i_cnt      (up_e.cnt),
      .i_taken    (i_upd_taken),
      .o_cnt_next (up_cnt_next)
   );

   // Next array contents: flush clears all valids and drops the update.
   always_comb begin
      entry_d = entry_q;
      up_idx  = i_upd_pc[IDX_W+1:2];
      up_e    = entry_q[up_idx];
      up_hit  = up_e.valid && (up_e.tag == i_upd_pc[XLEN-1:IDX_W+2]);
      if (i_flush) begin
         for (int unsigned i = 0; i < ENTRIES; i++) entry_d[i].valid = 1'b0;
      end else if (i_upd_vld) begin
         if (up_hit && i_upd_is_jmp) begin
            entry_d[up_idx].target = i_upd_target;
            entry_d[up_idx].is_jmp = 1'b1;
         end else if (up_hit) begin
            entry_d[up_idx].cnt = up_cnt_next;
            if (i_upd_taken) entry_d[up_idx].target = i_upd_target;
         end else if (i_upd_taken) begin
            entry_d[up_idx].valid  = 1'b1;
            entry_d[up_idx].tag    = i_upd_pc[XLEN-1:IDX_W+2];
            entry_d[up_idx].target = i_upd_target;
            entry_d[up_idx].cnt    = CNT_WT;
            entry_d[up_idx].is_jmp = i_upd_is_jmp;
         end
      end
   end

   // Array register; only valid bits are reset.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int unsigned i = 0; i < ENTRIES; i++) entry_q[i].valid <= 1'b0;
      end else begin
         entry_q <= entry_d;
      end
   end

`ifdef BPU_PERF_EN
   logic [31:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

   // Saturating event counters, insensitive to flush.
   always_comb begin
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (i_upd_vld && (br_cnt_q != '1))    br_cnt_d   = br_cnt_q + 32'd1;
      if (o_redirect && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign o_br_cnt   = br_cnt_q;
   assign o_miss_cnt = miss_cnt_q;
`else
   assign o_br_cnt   = '0;
   assign o_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// Self-checking bench for bpu_btb: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_bpu_btb;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] if_pc = '0;
   logic        hit, pred_taken;
   logic [31:0] pred_pc;
   logic        upd_vld = 1'b0, upd_is_jmp = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
   logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_pc = '0;
   logic        redirect;
   logic [31:0] redirect_pc, br_cnt, miss_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   bpu_btb #(.ENTRIES(32), .XLEN(32), .CNT_W(2)) dut (
      .i_clk            (clk),
      .i_rstn           (rstn),
      .i_flush          (flush),
      .i_if_pc          (if_pc),
      .o_hit            (hit),
      .o_pred_taken     (pred_taken),
      .o_pred_pc        (pred_pc),
      .i_upd_vld        (upd_vld),
      .i_upd_is_jmp     (upd_is_jmp),
      .i_upd_pc         (upd_pc),
      .i_upd_taken      (upd_taken),
      .i_upd_target     (upd_target),
      .i_upd_pred_taken (upd_pred_taken),
      .i_upd_pred_pc    (upd_pred_pc),
      .o_redirect       (redirect),
      .o_redirect_pc    (redirect_pc),
      .o_br_cnt         (br_cnt),
      .o_miss_cnt       (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid [32];
   logic [31:0] m_tag   [32];
   logic [31:0] m_tgt   [32];
   int          m_cnt   [32];
   bit          m_jmp   [32];
   logic [31:0] m_br = 0, m_miss = 0;

   function automatic int unsigned slot(input logic [31:0] pc);
      return (pc >> 2) % 32;
   endfunction

   function automatic bit present(input logic [31:0] pc);
      return m_valid[slot(pc)] && (m_tag[slot(pc)] == (pc >> 7));
   endfunction

   function automatic logic [31:0] resolved_next();
      return upd_taken ? upd_target : upd_pc + 32'd4;
   endfunction

   task automatic model_step();
      int unsigned s;
      bit mispred;
      mispred = upd_vld && (resolved_next() != upd_pred_pc);
      if (upd_vld && m_br != 32'hFFFF_FFFF) m_br++;
      if (mispred && m_miss != 32'hFFFF_FFFF) m_miss++;
      s = slot(upd_pc);
      if (flush) begin
         for (int i = 0; i < 32; i++) m_valid[i] = 0;
      end else if (upd_vld) begin
         if (present(upd_pc) && upd_is_jmp) begin
            m_tgt[s] = upd_target;
            m_jmp[s] = 1;
         end else if (present(upd_pc)) begin
            if (upd_taken) begin
               m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
               m_tgt[s] = upd_target;
            end else begin
               m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
            end
         end else if (upd_taken) begin
            m_valid[s] = 1;
            m_tag[s]   = upd_pc >> 7;
            m_tgt[s]   = upd_target;
            m_cnt[s]   = 2;
            m_jmp[s]   = upd_is_jmp;
         end
      end
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) m_valid[i] = 0;
         m_br   = 0;
         m_miss = 0;
      end else begin
         model_step();
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      bit          e_hit, e_tk;
      logic [31:0] e_pc, e_br, e_miss;
      e_hit = present(if_pc);
      e_tk  = e_hit && (m_jmp[slot(if_pc)] || m_cnt[slot(if_pc)] >= 2);
      e_pc  = e_tk ? m_tgt[slot(if_pc)] : if_pc + 32'd4;
`ifdef BPU_PERF_EN
      e_br   = m_br;
      e_miss = m_miss;
`else
      e_br   = 0;
      e_miss = 0;
`endif
      check("hit",         {31'b0, hit},        {31'b0, e_hit});
      check("pred_taken",  {31'b0, pred_taken}, {31'b0, e_tk});
      check("pred_pc",     pred_pc,             e_pc);
      check("redirect",    {31'b0, redirect},   {31'b0, upd_vld && (resolved_next() != upd_pred_pc)});
      check("redirect_pc", redirect_pc,         resolved_next());
      check("br_cnt",      br_cnt,              e_br);
      check("miss_cnt",    miss_cnt,            e_miss);
   end

   // ---------------- stimulus ----------------
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic v, input logic j, input logic [31:0] pc,
                          input logic t, input logic [31:0] tg, input logic [31:0] pp);
      upd_vld        = v;
      upd_is_jmp     = j;
      upd_pc         = pc;
      upd_taken      = t;
      upd_target     = tg;
      upd_pred_pc    = pp;
      upd_pred_taken = (pp != pc + 32'd4);
   endtask

   initial begin
      logic [31:0] pc, tg, pp;
      bit t, j;
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      next_cyc();

      // Empty lookup after reset
      if_pc = 32'h40; set_upd(0, 0, 0, 0, 0, 32'h4);
      #2;
      check("rst_hit", {31'b0, hit}, 32'd0);
      check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
      check("rst_pred_pc", pred_pc, 32'h44);
      check("rst_br_cnt", br_cnt, 32'd0);
      check("rst_miss_cnt", miss_cnt, 32'd0);
      next_cyc();

      // Allocate 0x40 -> 0x100
      set_upd(1, 0, 32'h40, 1, 32'h100, 32'h44);
      #2;
      check("alloc_redirect", {31'b0, redirect}, 32'd1);
      check("alloc_redirect_pc", redirect_pc, 32'h100);
      next_cyc();
      set_upd(0, 0, 0, 0, 0, 32'h4);
      #2;
      check("alloc_hit", {31'b0, hit}, 32'd1);
      check("alloc_pred_pc", pred_pc, 32'h100);

      // Three not-taken: WT -> WNT -> SNT -> SNT
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         set_upd(1, 0, 32'h40, 0, 32'h0, 32'h44);
      end
      next_cyc();
      set_upd(0, 0, 0, 0, 0, 32'h4);
      #2;
      check("sat_pred_pc", pred_pc, 32'h44);
      check("sat_pred_taken", {31'b0, pred_taken}, 32'd0);
      next_cyc();
      set_upd(1, 0, 32'h40, 0, 32'h0, 32'h44);
      #2;
      check("nt_no_redirect", {31'b0, redirect}, 32'd0);
      next_cyc();

      // Aliasing JAL at 0xC0 replaces slot 16
      set_upd(1, 1, 32'hC0, 1, 32'h200, 32'hC4);
      #2;
      check("jal_redirect", {31'b0, redirect}, 32'd1);
      next_cyc();
      set_upd(0, 0, 0, 0, 0, 32'h4);
      #2;
      check("alias_old_miss", {31'b0, hit}, 32'd0);
      if_pc = 32'hC0;
      #1;
      check("jal_pred_pc", pred_pc, 32'h200);
      for (int i = 0; i < 2; i++) begin
         next_cyc();
         set_upd(1, 0, 32'hC0, 0, 32'h0, 32'hC4);
      end
      next_cyc();
      set_upd(0, 0, 0, 0, 0, 32'h4);
      #2;
      check("jmp_ignores_cnt", pred_pc, 32'h200);
      next_cyc();

      // Flush wins over a simultaneous update
      flush = 1'b1;
      set_upd(1, 0, 32'h80, 1, 32'h300, 32'h84);
      #2;
      check("flush_redirect", {31'b0, redirect}, 32'd1);
      check("flush_redirect_pc", redirect_pc, 32'h300);
      next_cyc();
      flush = 1'b0;
      set_upd(0, 0, 0, 0, 0, 32'h4);
      #2;
      check("flush_cleared", {31'b0, hit}, 32'd0);
      if_pc = 32'h80;
      #1;
      check("flush_no_alloc", {31'b0, hit}, 32'd0);
      next_cyc();

      // Same-slot lookup during update sees old contents
      if_pc = 32'h40;
      set_upd(1, 0, 32'h40, 1, 32'h500, 32'h44);
      #2;
      check("no_bypass", {31'b0, hit}, 32'd0);
      next_cyc();
      set_upd(0, 0, 0, 0, 0, 32'h4);
      #2;
      check("post_write_pc", pred_pc, 32'h500);
      next_cyc();

      // PC+4 wrap
      if_pc = 32'hFFFF_FFFC;
      set_upd(1, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
      #2;
      check("wrap_pred_pc", pred_pc, 32'h0);
      check("wrap_redirect", {31'b0, redirect}, 32'd0);
      check("wrap_redirect_pc", redirect_pc, 32'h0);
      next_cyc();

      // Asynchronous reset mid-cycle
      if_pc = 32'h40;
      set_upd(0, 0, 0, 0, 0, 32'h4);
      #1;
      check("pre_reset_hit", {31'b0, hit}, 32'd1);
      rstn = 1'b0;
      #1;
      check("async_rst_hit", {31'b0, hit}, 32'd0);
      check("async_rst_pred_pc", pred_pc, 32'h44);
      check("async_rst_redirect", {31'b0, redirect}, 32'd0);
      check("async_rst_br", br_cnt, 32'd0);
      check("async_rst_miss", miss_cnt, 32'd0);
      next_cyc();
      #3 rstn = 1'b1;
      next_cyc();

      // Ten updates, four mispredicts
      for (int i = 0; i < 10; i++) begin
         pc = 32'h1000 + 32'(8 * i);
         set_upd(1, 0, pc, 1, 32'h2000, (i % 3 == 0) ? pc + 32'd4 : 32'h2000);
         next_cyc();
      end
      set_upd(0, 0, 0, 0, 0, 32'h4);
      #2;
`ifdef BPU_PERF_EN
      check("perf_br", br_cnt, 32'd10);
      check("perf_miss", miss_cnt, 32'd4);
`else
      check("perf_br_off", br_cnt, 32'd0);
      check("perf_miss_off", miss_cnt, 32'd0);
`endif
      next_cyc();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         pc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2)
              | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FF80 | (pc & 32'h7F);
         j  = ($urandom_range(0, 4) == 0);
         t  = j || $urandom_range(0, 1) == 1;
         tg = $urandom;
         case ($urandom_range(0, 2))
            0:       pp = t ? tg : pc + 32'd4;
            1:       pp = pc + 32'd4;
            default: pp = tg;
         endcase
         set_upd($urandom_range(0, 3) != 0, j, pc, t, tg, pp);
         flush = ($urandom_range(0, 39) == 0);
         if_pc = ($urandom_range(0, 1) == 1) ? pc :
                 (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
         next_cyc();
      end
      flush = 1'b0;
      set_upd(0, 0, 0, 0, 0, 32'h4);
      next_cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
